// File: rtl/arm_poll_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : arm_poll_scheduler_if
//  Description : Signal bundle between the poll scheduler, the arm I2C
//                controller (request/done/ack_error/angle) and the host
//                register block (enables, angle result, health counters).
//                master = scheduler side, slave = controller/host side.
//  Revision    : 1.0  initial release
// ============================================================================
interface arm_poll_scheduler_if;
    // host controls
    logic        enable;
    logic        read_angle_enable;
    logic        write_hand_enable;
    logic        hand_update;
    // arm I2C controller handshake
    logic        arm_done;
    logic        arm_ack_error;
    logic [11:0] arm_angle;
    logic        elbow_read_joint_angle;
    logic        write_hand;
    // host results
    logic [11:0] angle_out;
    logic        angle_valid;
    logic        busy;
    logic [15:0] error_count;
    logic [15:0] timeout_count;
    logic [15:0] overrun_count;

    modport master (
        input  enable, read_angle_enable, write_hand_enable, hand_update,
        input  arm_done, arm_ack_error, arm_angle,
        output elbow_read_joint_angle, write_hand,
        output angle_out, angle_valid, busy,
        output error_count, timeout_count, overrun_count
    );

    modport slave (
        output enable, read_angle_enable, write_hand_enable, hand_update,
        output arm_done, arm_ack_error, arm_angle,
        input  elbow_read_joint_angle, write_hand,
        input  angle_out, angle_valid, busy,
        input  error_count, timeout_count, overrun_count
    );
endinterface
`default_nettype wire

// File: rtl/arm_poll_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : arm_poll_scheduler
//  Description : Periodic request scheduler for the arm I2C controller.
//                Every PERIOD = CLOCK_FREQ/UPDATE_FREQ cycles it issues an
//                elbow angle read and, when a hand frame is pending, a hand
//                write. Each transaction is tracked through the controller's
//                done handshake and bounded by TIMEOUT_CYCLES.
//  Ports       : clock, reset (async, active high)
//                bus.master : enable, read_angle_enable, write_hand_enable,
//                  hand_update, arm_done, arm_ack_error, arm_angle (in);
//                  elbow_read_joint_angle, write_hand, angle_out,
//                  angle_valid, busy, error_count, timeout_count,
//                  overrun_count (out)
//  Revision    : 1.0  initial release
// ============================================================================
module arm_poll_scheduler #(
    parameter int CLOCK_FREQ     = 50000000,
    parameter int UPDATE_FREQ    = 100,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  wire logic            clock,
    input  wire logic            reset,
    arm_poll_scheduler_if.master bus
);

    localparam int PERIOD = CLOCK_FREQ / UPDATE_FREQ;
    localparam int CNT_W  = $clog2(PERIOD);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE             = 3'd0,
        ISSUE_READ       = 3'd1,
        WAIT_READ_START  = 3'd2,
        WAIT_READ_DONE   = 3'd3,
        ISSUE_WRITE      = 3'd4,
        WAIT_WRITE_START = 3'd5,
        WAIT_WRITE_DONE  = 3'd6
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] period_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             tick;
    logic             to_last;
    logic             err_flag;
    logic             err_now;
    logic             hand_pending;
    logic             in_wait;
    logic             complete;
    logic             timed_out;
    logic             elbow_req;
    logic             write_req;
    logic             busy_int;
    logic [11:0]      angle_reg;
    logic             angle_valid_reg;
    logic [15:0]      error_cnt;
    logic [15:0]      timeout_cnt;
    logic [15:0]      overrun_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // tick marks the cycle in which the period counter wraps back to 0
    assign tick    = bus.enable && (period_cnt == PERIOD_LAST);
    assign to_last = (to_cnt == TO_LAST);
    // an ack error seen in the completion cycle itself still counts
    assign err_now = err_flag | bus.arm_ack_error;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period_cnt <= '0;
        end else if (!bus.enable || tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and strobes. Request strobes decode straight from the state
    // register so an asynchronous reset drops them at once.
    always_comb begin
        next_state = state;
        elbow_req  = 1'b0;
        write_req  = 1'b0;
        busy_int   = 1'b1;
        in_wait    = 1'b0;
        complete   = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                busy_int = 1'b0;
                if (tick) begin
                    if (bus.read_angle_enable) begin
                        next_state = ISSUE_READ;
                    end else if (bus.write_hand_enable && hand_pending) begin
                        next_state = ISSUE_WRITE;
                    end
                end
            end
            ISSUE_READ: begin
                elbow_req  = 1'b1;
                next_state = WAIT_READ_START;
            end
            WAIT_READ_START: begin
                in_wait = 1'b1;
                if (to_last) begin
                    timed_out  = 1'b1;
                    next_state = IDLE;
                end else if (!bus.arm_done) begin
                    next_state = WAIT_READ_DONE;
                end
            end
            WAIT_READ_DONE: begin
                in_wait = 1'b1;
                // completion takes priority over a timeout in the same cycle
                if (bus.arm_done) begin
                    complete = 1'b1;
                    if (bus.write_hand_enable && hand_pending) begin
                        next_state = ISSUE_WRITE;
                    end else begin
                        next_state = IDLE;
                    end
                end else if (to_last) begin
                    timed_out  = 1'b1;
                    next_state = IDLE;
                end
            end
            ISSUE_WRITE: begin
                write_req  = 1'b1;
                next_state = WAIT_WRITE_START;
            end
            WAIT_WRITE_START: begin
                in_wait = 1'b1;
                if (to_last) begin
                    timed_out  = 1'b1;
                    next_state = IDLE;
                end else if (!bus.arm_done) begin
                    next_state = WAIT_WRITE_DONE;
                end
            end
            WAIT_WRITE_DONE: begin
                in_wait = 1'b1;
                if (bus.arm_done) begin
                    complete   = 1'b1;
                    next_state = IDLE;
                end else if (to_last) begin
                    timed_out  = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                busy_int   = 1'b0;
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_flag        <= 1'b0;
            to_cnt          <= '0;
            hand_pending    <= 1'b0;
            angle_reg       <= 12'd0;
            angle_valid_reg <= 1'b0;
            error_cnt       <= 16'd0;
            timeout_cnt     <= 16'd0;
            overrun_cnt     <= 16'd0;
        end else begin
            angle_valid_reg <= 1'b0;

            if (state == ISSUE_READ || state == ISSUE_WRITE) begin
                err_flag <= 1'b0;
                to_cnt   <= '0;
            end else if (in_wait) begin
                err_flag <= err_now;
                to_cnt   <= to_cnt + TO_W'(1);
            end

            if (complete) begin
                if (err_now) begin
                    error_cnt <= sat_inc(error_cnt);
                end else if (state == WAIT_READ_DONE) begin
                    angle_reg       <= bus.arm_angle;
                    angle_valid_reg <= 1'b1;
                end
            end

            if (timed_out) begin
                timeout_cnt <= sat_inc(timeout_cnt);
            end

            // ticks landing outside IDLE are dropped, never queued
            if (tick && state != IDLE) begin
                overrun_cnt <= sat_inc(overrun_cnt);
            end

            // a new frame arriving while the write is being issued stays pending
            if (state == ISSUE_WRITE) begin
                hand_pending <= bus.hand_update;
            end else begin
                hand_pending <= hand_pending | bus.hand_update;
            end
        end
    end

    assign bus.elbow_read_joint_angle = elbow_req;
    assign bus.write_hand             = write_req;
    assign bus.busy                   = busy_int;
    assign bus.angle_out              = angle_reg;
    assign bus.angle_valid            = angle_valid_reg;
    assign bus.error_count            = error_cnt;
    assign bus.timeout_count          = timeout_cnt;
    assign bus.overrun_count          = overrun_cnt;

endmodule
`default_nettype wire

// File: doc/arm_poll_scheduler.md
# arm_poll_scheduler

Periodic transaction scheduler that drives the arm I2C controller's `elbow_read_joint_angle` and `write_hand` request inputs. It issues requests, tracks the controller's `done` handshake and guards each transaction with a timeout. It publishes the last good elbow angle plus saturating health counters to the host register block. It sits directly upstream of the arm I2C controller and is the only source of its request strobes.

## Interface
- `CLOCK_FREQ`, 50000000: clock frequency in Hz.
- `UPDATE_FREQ`, 100: polling rate in Hz. PERIOD = CLOCK_FREQ/UPDATE_FREQ cycles, integer division, must be ≥ 4.
- `TIMEOUT_CYCLES`, 1000000: maximum cycles spent waiting on one transaction.

Ports:
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: run the period timer. When low, the period counter holds at 0.
- `read_angle_enable` in 1: include an angle read in each period.
- `write_hand_enable` in 1: allow hand writes.
- `hand_update` in 1: single-cycle pulse; new command frames are available and a write is pending.
- `arm_done` in 1: `done` from the controller; high when idle.
- `arm_ack_error` in 1: `ack_error` from the controller.
- `arm_angle` in 12: `angle` from the controller.
- `elbow_read_joint_angle` out 1: single-cycle read request.
- `write_hand` out 1: single-cycle write request.
- `angle_out` out 12: last angle read without error.
- `angle_valid` out 1: single-cycle pulse when `angle_out` updates.
- `busy` out 1: high in every state except IDLE.
- `error_count` out 16: transactions that saw `arm_ack_error`. Saturates at 0xFFFF.
- `timeout_count` out 16: transactions that timed out. Saturates at 0xFFFF.
- `overrun_count` out 16: ticks dropped while busy. Saturates at 0xFFFF.

## Operation
- **Period counter.** Counts 0..PERIOD-1 while `enable` is high.
  - The cycle it wraps to 0 produces an internal `tick`.
  - When `enable` is low, the counter clears.
- **Pending write.** `hand_pending` is set by `hand_update` and cleared in the cycle ISSUE_WRITE is entered.
  - A `hand_update` arriving in that same cycle wins: `hand_pending` stays 1.
- **FSM states:** IDLE, ISSUE_READ, WAIT_READ_START, WAIT_READ_DONE, ISSUE_WRITE, WAIT_WRITE_START, WAIT_WRITE_DONE.
- **IDLE, on `tick`:**
  - If `read_angle_enable`, go to ISSUE_READ.
  - Else if `write_hand_enable && hand_pending`, go to ISSUE_WRITE.
  - Else stay in IDLE.
- **ISSUE_x:**
  - Assert the matching request for exactly 1 cycle.
  - Clear `err_flag` and the timeout counter.
  - Go to WAIT_x_START.
- **WAIT_x_START:** wait for `arm_done`=0, then go to WAIT_x_DONE.
- **WAIT_x_DONE:** wait for `arm_done`=1, then complete.
- **Error flag.** In both wait states, `arm_ack_error`=1 in any cycle sets the sticky `err_flag`.
- **Read completion:**
  - If `err_flag` is 0: `angle_out` ← `arm_angle`, and `angle_valid` pulses.
  - If `err_flag` is 1: `error_count` increments and `angle_out` holds.
  - Then, if `write_hand_enable && hand_pending`, go to ISSUE_WRITE; else go to IDLE.
- **Write completion:** if `err_flag` is set, `error_count` increments. Go to IDLE.
- **Timeout.** The timeout counter runs in both wait states of a transaction. When it reaches TIMEOUT_CYCLES:
  - `timeout_count` increments.
  - `angle_out` is not updated.
  - The FSM goes to IDLE and abandons any chained write; `hand_pending` is unchanged if the write was never issued.
- **Overrun.** A `tick` in any state other than IDLE increments `overrun_count` and is dropped; it is never queued.
- **Exclusive requests.** `elbow_read_joint_angle` and `write_hand` are never high in the same cycle.
- **Disable mid-transaction.** `enable` going low does not abort a transaction in flight. It only stops further ticks.
- **Reset mid-transaction.** Reset forces IDLE. All request strobes go low immediately (asynchronously).

## Timing
- **Reset values:**
  - `elbow_read_joint_angle`, `write_hand`, `angle_valid`, `busy` = 0.
  - `angle_out` = 0.
  - All three counters = 0.
  - `hand_pending` = 0, period counter = 0, FSM in IDLE.
- **Request latency:** the request strobe is high in the cycle after the `tick` cycle.
- **Controller response:** the controller drops `done` the cycle after it samples the request. WAIT_x_START must tolerate any delay up to the timeout.
- **Angle latency:** `angle_out` and `angle_valid` are registered in the cycle after `arm_done` is sampled high in WAIT_READ_DONE.
- **Chained write:** the `write_hand` strobe follows read completion by 1 cycle (the ISSUE_WRITE cycle).
- **Counter outputs:** registered, updated 1 cycle after the triggering event.
- **Simultaneous events:** `tick` and completion in the same cycle count as an overrun, because the FSM is not yet in IDLE.

## Test plan
Bench parameters: CLOCK_FREQ=1000, UPDATE_FREQ=100 (PERIOD=10), TIMEOUT_CYCLES=20. The controller model drops `done` 1 cycle after a request and raises it 5 cycles later.

- **Normal read.** `enable`=1, `read_angle_enable`=1, model angle 0x2A5.
  - Exactly one `elbow_read_joint_angle` pulse per 10 cycles.
  - `angle_out`=0x2A5 with a 1-cycle `angle_valid` pulse per period.
- **Chained write.** `hand_update` pulse, then the next tick.
  - Read completes, then `write_hand` pulses 1 cycle later.
  - Following periods issue reads only.
- **ACK error.** Model holds `arm_ack_error`=1 during one read.
  - `error_count`=1, `angle_out` keeps its previous value, no `angle_valid` pulse.
- **Timeout.** Model never raises `done`.
  - 20 wait cycles, then `timeout_count`=1 and the FSM returns to IDLE.
  - The next tick issues a new read.
- **Overrun.** Model takes 15 cycles per transaction: `overrun_count` increments on every tick that lands while busy.
- **Reset mid-wait.** Assert `reset` in WAIT_READ_DONE.
  - All outputs return to their reset values.
  - After release, the first request appears 1 cycle after the first tick.
